nn_mac_stage: RTL
=================

// Module: nn_mac_stage
// PURPOSE
//  Consumer stage directly downstream of the input FIFO in the wishbone_nn datapath.
//  - Pops packed 32-bit input words: 4 signed 8-bit lanes, lane0 = bits[7:0].
//  - Multiplies each word lane-wise with a stored weight word and accumulates the result.
//  - After NUM_WORDS words, outputs one saturated neuron result over a valid/ready handshake.
// PARAMETERS
//  NUM_WORDS  8   words per dot product; also the weight bank depth (>=2)
//  ACC_W      24  accumulator width, signed
//  OUT_W      16  result width, signed, saturated from ACC_W
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      asynchronous, active-high reset
//  start_i         in   1      begin a dot product; sampled only in IDLE
//  fifo_empty_i    in   1      FIFO has no data
//  fifo_rd_o       out  1      pop strobe; fifo_data_i is show-ahead (valid while !empty)
//  fifo_data_i     in   32     packed input word
//  w_we_i          in   1      weight-bank write enable
//  w_addr_i        in   clog2(NUM_WORDS)  weight word index
//  w_data_i        in   32     packed weights, same lane order as the data
//  busy_o          out  1      state != IDLE
//  result_o        out  OUT_W  signed result, held while result_valid_o is high
//  result_valid_o  out  1      result available
//  result_ready_i  in   1      downstream accepts the result
// BEHAVIOUR
//  - Reset values: fifo_rd_o=0, busy_o=0, result_o=0, result_valid_o=0, acc=0, idx=0, state=IDLE.
//  - Weight bank contents are not reset.
//  - Reset asserted mid-operation aborts immediately. No FIFO pop is issued during reset.
//  - FSM states:
//    - IDLE: start_i=1 -> RUN, with acc=0 and idx=0.
//    - RUN: fifo_rd_o = !fifo_empty_i (combinational). On a pop:
//      - acc += sum(i=0..3) data.lane[i]*w[idx].lane[i] (signed 8x8 products, sign-extended to ACC_W).
//      - idx increments.
//      - When a pop occurs with idx==NUM_WORDS-1 -> OUT.
//      - fifo_empty_i=1 stalls without penalty; acc and idx hold.
//    - OUT: result_valid_o=1 and result_o is stable. result_ready_i=1 -> IDLE, and valid drops the next cycle.
//  - Latency: with the FIFO never empty, start accepted at cycle 0 gives pops in cycles 1..NUM_WORDS and result_valid_o at cycle NUM_WORDS+1.
//  - Throughput: 1 word/cycle in RUN.
//  - Saturation: result_o = clamp(acc_final, -2^(OUT_W-1), 2^(OUT_W-1)-1). The clamp is computed on the final acc, registered on entry to OUT.
//  - acc arithmetic wraps at ACC_W. Defaults (8 words x 4 x 2^14) cannot overflow.
//  - start_i in RUN or OUT is ignored. No queueing.
//  - Weight writes are accepted only in IDLE and dropped otherwise. A write to address >= NUM_WORDS is dropped.
//  - A start_i and w_we_i in the same IDLE cycle: the write lands, and RUN uses the new weight.
//  - fifo_rd_o is never asserted outside RUN and never while fifo_empty_i=1.
// CONFIGURATION
//  NN_MAC_RELU_EN
//  - Defined: ReLU is applied after saturation, so negative results become 0 and positive results pass unchanged.
//  - Undefined: the signed saturated result passes through unchanged.
// STRUCTURE
//  - Package nn_pkg:
//    - LANE_W=8, LANES=4, WORD_W=32
//    - State encoding: IDLE=2'd0, RUN=2'd1, OUT=2'd2
//    - Saturation function sat_to_out(acc).
//  - Sub-module nn_dot4: combinational 4-lane signed 8x8 dot product, 18-bit signed output. Instantiated once.
//  - Weight bank: NUM_WORDS x 32 register array, held locally.
// TESTING
//  1. All weights 0x01010101, 8 words of 0x02020202, FIFO always full, start
//     -> 8 consecutive pops; result_o=64; valid at cycle 9.
//  2. Weights 0x7F7F7F7F, data 0x7F7F7F7F x8
//     -> acc=516128; result_o=32767 (saturated). Data 0x80808080, weights 0x7F7F7F7F
//     -> result_o=-32768, or 0 with NN_MAC_RELU_EN.
//  3. As test 1, but fifo_empty_i toggles every other cycle
//     -> no pop while empty; result_o still 64; valid after 16 cycles.
//  4. result_ready_i held low 5 cycles in OUT
//     -> result_o stable and valid high all 5 cycles; start_i pulses ignored; IDLE one cycle after ready.
//  5. rst pulsed after 3 pops
//     -> outputs at reset values immediately; a new run (weights intact) gives the correct fresh result.
//  6. w_we_i to idx 2 during RUN is dropped; the same write in IDLE then a run
//     -> lane products for idx 2 use the new weight.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types, lane geometry and arithmetic helpers for the nn MAC datapath.
package nn_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DOT_W  = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Signed 8x8 lane product; the 16-bit return width forces a full-width signed multiply.
  function automatic logic signed [2*LANE_W-1:0] mul8(input logic signed [LANE_W-1:0] x,
                                                      input logic signed [LANE_W-1:0] z);
    return x * z;
  endfunction

  // Clamp a sign-extended accumulator into the signed range of an out_w-bit result.
  function automatic logic signed [31:0] sat_to_out(input logic signed [31:0] acc,
                                                    input int unsigned out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/nn_dot4.sv
// Combinational 4-lane signed 8x8 dot product of two packed words.
module nn_dot4
  import nn_pkg::*;
(
  input  logic [WORD_W-1:0]       a,
  input  logic [WORD_W-1:0]       b,
  output logic signed [DOT_W-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      y = y + DOT_W'(mul8(a[i*LANE_W +: LANE_W], b[i*LANE_W +: LANE_W]));
    end
  end

endmodule

// File: rtl/nn_mac_stage.sv
// FIFO-fed MAC stage: accumulates NUM_WORDS lane-wise dot products, emits one saturated result.
// Build option NN_MAC_RELU_EN clamps negative results to zero after saturation.
module nn_mac_stage
  import nn_pkg::*;
#(
  parameter  int unsigned NUM_WORDS = 8,
  parameter  int unsigned ACC_W     = 24,
  parameter  int unsigned OUT_W     = 16,
  localparam int unsigned AW        = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  input  logic [WORD_W-1:0] fifo_data_i,
  input  logic              w_we_i,
  input  logic [AW-1:0]     w_addr_i,
  input  logic [WORD_W-1:0] w_data_i,
  output logic              busy_o,
  output logic [OUT_W-1:0]  result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i
);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [AW-1:0]            idx_q, idx_d;
  logic [OUT_W-1:0]         result_d, res_next;
  logic signed [OUT_W-1:0]  sat;
  logic                     valid_d, busy_d, pop;
  logic signed [DOT_W-1:0]  dot;
  logic [WORD_W-1:0]        w_bank [NUM_WORDS];

  assign pop       = (state_q == RUN) && !fifo_empty_i;
  assign fifo_rd_o = pop;

  nn_dot4 u_dot4 (
    .a (fifo_data_i),
    .b (w_bank[idx_q]),
    .y (dot)
  );

  assign acc_sum = acc_q + ACC_W'(dot);
  assign sat     = OUT_W'(sat_to_out(32'(acc_sum), OUT_W));

`ifdef NN_MAC_RELU_EN
  assign res_next = sat[OUT_W-1] ? '0 : sat;
`else
  assign res_next = sat;
`endif

  // Weights are only writable while idle; the bank is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we_i && (state_q == IDLE) && (32'(w_addr_i) < NUM_WORDS)) begin
      w_bank[w_addr_i] <= w_data_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_o;
    valid_d  = result_valid_o;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (pop) begin
          acc_d = acc_sum;
          idx_d = idx_q + AW'(1);
          if (idx_q == AW'(NUM_WORDS - 1)) begin
            state_d  = OUT;
            result_d = res_next;
            valid_d  = 1'b1;
          end
        end
      end
      OUT: begin
        if (result_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      idx_q          <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      result_o       <= result_d;
      result_valid_o <= valid_d;
      busy_o         <= busy_d;
    end
  end

endmodule
